// File: rtl/data_break.sv
// ---------------------------------------------------------------------------
// data_break
//
// Multi-channel data-break (DMA) controller and memory-bus arbiter sitting
// between the CPU memory-address block, CHANNELS peripheral DMA ports and
// the synchronous main RAM.
//
// Single-cycle break : peripheral supplies the full transfer address.
// Three-cycle break  : word count (at {0,wcp}) and current address (at
//                      {0,wcp+1}) live in memory; both are incremented here
//                      and the transfer goes to {field, ca+1}.
//
// Ports
//   clk, reset     system clock, asynchronous active-high reset
//   break_ok       CPU is at a major-state boundary, a break may start
//   cpu_addr/wdata/we   CPU bus request, passed through while cpu_hold=0
//   req            per-channel level break request
//   to_mem         per-channel direction (1 = write to memory)
//   three_cycle    per-channel three-cycle mode
//   ch_addr        per-channel address (AW bits each)
//   ch_wdata       per-channel write data (12 bits each)
//   ack            one-cycle completion pulse, one bit per channel
//   ch_rdata       read data, valid while ack is high
//   wc_overflow    word count wrapped to 0000 on this break, valid with ack
//   cpu_hold       break in progress, CPU must freeze
//   mem_addr/wdata/we   RAM request
//   mem_rdata      RAM read data, one cycle after the address
// ---------------------------------------------------------------------------
module data_break #(
    parameter int CHANNELS    = 2,
    parameter int FIELD_BITS  = 3,
    parameter int ROUND_ROBIN = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                break_ok,
    input  logic [FIELD_BITS+11:0]              cpu_addr,
    input  logic [11:0]                         cpu_wdata,
    input  logic                                cpu_we,
    input  logic [CHANNELS-1:0]                 req,
    input  logic [CHANNELS-1:0]                 to_mem,
    input  logic [CHANNELS-1:0]                 three_cycle,
    input  logic [CHANNELS*(FIELD_BITS+12)-1:0] ch_addr,
    input  logic [CHANNELS*12-1:0]              ch_wdata,
    output logic [CHANNELS-1:0]                 ack,
    output logic [11:0]                         ch_rdata,
    output logic                                wc_overflow,
    output logic                                cpu_hold,
    output logic [FIELD_BITS+11:0]              mem_addr,
    output logic [11:0]                         mem_wdata,
    output logic                                mem_we,
    input  logic [11:0]                         mem_rdata
);

    localparam int AW = FIELD_BITS + 12;
    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_WA   = 4'd1;
    localparam logic [3:0] S_WD   = 4'd2;
    localparam logic [3:0] S_WW   = 4'd3;
    localparam logic [3:0] S_CA   = 4'd4;
    localparam logic [3:0] S_CD   = 4'd5;
    localparam logic [3:0] S_CW   = 4'd6;
    localparam logic [3:0] S_XA   = 4'd7;
    localparam logic [3:0] S_XD   = 4'd8;
    localparam logic [3:0] S_ACK  = 4'd9;

    logic [3:0]            state;
    logic [IW-1:0]         win;
    logic [IW-1:0]         rr_last;
    logic                  to_mem_r;
    logic [11:0]           wcp_r;
    logic [FIELD_BITS-1:0] field_r;
    logic [AW-1:0]         xfer_addr;
    logic [11:0]           word_r;
    logic [11:0]           data_r;
    logic                  ovf_r;
    logic [11:0]           rdata_r;

    // Arbiter outputs
    logic                  grant_found;
    logic [IW-1:0]         grant_idx;
    logic [AW-1:0]         sel_addr;
    logic [11:0]           sel_wdata;
    logic                  sel_to_mem;
    logic                  sel_three;
    logic [IW-1:0]         rr_next;
    logic                  grant_go;

    logic [11:0]           rdata_inc;
    logic [11:0]           wcp_inc;

    // Internal bus request while the CPU is held
    logic [AW-1:0]         bus_addr;
    logic [11:0]           bus_wdata;
    logic                  bus_we;

    assign rdata_inc = mem_rdata + 12'd1;
    assign wcp_inc   = wcp_r + 12'd1;

    assign rr_next = (int'(rr_last) == CHANNELS - 1) ? '0 : rr_last + 1'b1;

    // Search all channels starting from a rotating (or fixed zero) origin;
    // the first requesting channel wins and its inputs are selected.
    always_comb begin
        int unsigned start;
        int unsigned idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        sel_addr    = '0;
        sel_wdata   = '0;
        sel_to_mem  = 1'b0;
        sel_three   = 1'b0;
        start       = (ROUND_ROBIN != 0) ? int'(rr_next) : 0;
        idx         = 0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            idx = start + i;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (!grant_found && req[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(idx);
                sel_addr    = ch_addr[idx*AW +: AW];
                sel_wdata   = ch_wdata[idx*12 +: 12];
                sel_to_mem  = to_mem[idx];
                sel_three   = three_cycle[idx];
            end
        end
    end

    // Leaving ACK behaves like IDLE so back-to-back breaks lose no cycle.
    assign grant_go = grant_found && break_ok &&
                      ((state == S_IDLE) || (state == S_ACK));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            win       <= '0;
            rr_last   <= IW'(CHANNELS - 1);
            to_mem_r  <= 1'b0;
            wcp_r     <= '0;
            field_r   <= '0;
            xfer_addr <= '0;
            word_r    <= '0;
            data_r    <= '0;
            ovf_r     <= 1'b0;
            rdata_r   <= '0;
        end else begin
            if (grant_go) begin
                win       <= grant_idx;
                rr_last   <= grant_idx;
                to_mem_r  <= sel_to_mem;
                xfer_addr <= sel_addr;
                wcp_r     <= sel_addr[11:0];
                field_r   <= sel_addr[AW-1:12];
                data_r    <= sel_wdata;
                ovf_r     <= 1'b0;
                state     <= sel_three ? S_WA : S_XA;
            end else begin
                case (state)
                    S_WA: state <= S_WD;
                    S_WD: begin
                        word_r <= rdata_inc;
                        ovf_r  <= (mem_rdata == 12'o7777);
                        state  <= S_WW;
                    end
                    S_WW: state <= S_CA;
                    S_CA: state <= S_CD;
                    S_CD: begin
                        // Field is never carried into; CA wraps within it.
                        word_r    <= rdata_inc;
                        xfer_addr <= {field_r, rdata_inc};
                        state     <= S_CW;
                    end
                    S_CW: state <= S_XA;
                    S_XA: state <= S_XD;
                    S_XD: begin
                        if (!to_mem_r) begin
                            rdata_r <= mem_rdata;
                        end
                        state <= S_ACK;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        bus_addr  = '0;
        bus_wdata = '0;
        bus_we    = 1'b0;
        case (state)
            S_WA, S_WD: begin
                bus_addr = {{FIELD_BITS{1'b0}}, wcp_r};
            end
            S_WW: begin
                bus_addr  = {{FIELD_BITS{1'b0}}, wcp_r};
                bus_wdata = word_r;
                bus_we    = 1'b1;
            end
            S_CA, S_CD: begin
                bus_addr = {{FIELD_BITS{1'b0}}, wcp_inc};
            end
            S_CW: begin
                bus_addr  = {{FIELD_BITS{1'b0}}, wcp_inc};
                bus_wdata = word_r;
                bus_we    = 1'b1;
            end
            S_XA: begin
                bus_addr  = xfer_addr;
                bus_wdata = data_r;
                bus_we    = to_mem_r;
            end
            S_XD: begin
                bus_addr = xfer_addr;
            end
            default: begin
                bus_addr  = '0;
                bus_wdata = '0;
                bus_we    = 1'b0;
            end
        endcase
    end

    assign cpu_hold  = (state != S_IDLE);
    assign mem_addr  = cpu_hold ? bus_addr  : cpu_addr;
    assign mem_wdata = cpu_hold ? bus_wdata : cpu_wdata;
    assign mem_we    = cpu_hold ? bus_we    : cpu_we;

    always_comb begin
        ack = '0;
        if (state == S_ACK) begin
            ack[win] = 1'b1;
        end
    end

    assign wc_overflow = (state == S_ACK) && ovf_r;
    assign ch_rdata    = rdata_r;

endmodule

// File: tb/tb_data_break.sv
module tb_data_break;

    localparam int CH = 2;
    localparam int FB = 3;
    localparam int AW = FB + 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              break_ok;
    logic [AW-1:0]     cpu_addr;
    logic [11:0]       cpu_wdata;
    logic              cpu_we;
    logic [CH-1:0]     req;
    logic [CH-1:0]     to_mem;
    logic [CH-1:0]     three_cycle;
    logic [CH*AW-1:0]  ch_addr;
    logic [CH*12-1:0]  ch_wdata;

    logic [CH-1:0]     ack,       ack_r;
    logic [11:0]       ch_rdata,  ch_rdata_r;
    logic              wc_overflow, wc_overflow_r;
    logic              cpu_hold,  cpu_hold_r;
    logic [AW-1:0]     mem_addr,  mem_addr_r;
    logic [11:0]       mem_wdata, mem_wdata_r;
    logic              mem_we,    mem_we_r;
    logic [11:0]       mem_rdata, mem_rdata_r;

    logic [11:0] ram0 [0:(1<<AW)-1];
    logic [11:0] ram1 [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [CH-1:0] ackv;
        logic [11:0]   data;
        logic          ovf;
    } exp_t;

    exp_t        sb[$];
    logic [11:0] last_rdata = '0;

    always #5 clk = ~clk;

    data_break #(.CHANNELS(CH), .FIELD_BITS(FB), .ROUND_ROBIN(0)) dut (
        .clk(clk), .reset(reset), .break_ok(break_ok),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .req(req), .to_mem(to_mem), .three_cycle(three_cycle),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ack(ack), .ch_rdata(ch_rdata), .wc_overflow(wc_overflow),
        .cpu_hold(cpu_hold), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    data_break #(.CHANNELS(CH), .FIELD_BITS(FB), .ROUND_ROBIN(1)) dut_rr (
        .clk(clk), .reset(reset), .break_ok(break_ok),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .req(req), .to_mem(to_mem), .three_cycle(three_cycle),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ack(ack_r), .ch_rdata(ch_rdata_r), .wc_overflow(wc_overflow_r),
        .cpu_hold(cpu_hold_r), .mem_addr(mem_addr_r), .mem_wdata(mem_wdata_r),
        .mem_we(mem_we_r), .mem_rdata(mem_rdata_r)
    );

    // Synchronous RAMs, read data one cycle after the address
    always @(posedge clk) begin
        if (mem_we) ram0[mem_addr] <= mem_wdata;
        mem_rdata <= ram0[mem_addr];
    end

    always @(posedge clk) begin
        if (mem_we_r) ram1[mem_addr_r] <= mem_wdata_r;
        mem_rdata_r <= ram1[mem_addr_r];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o expected %0o", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every ack must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!reset && ack != '0) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got %b expected none", ack);
            end else begin
                e = sb.pop_front();
                chk("sb_ack", 32'(ack), 32'(e.ackv));
                chk("sb_rdata", 32'(ch_rdata), 32'(e.data));
                chk("sb_ovf", 32'(wc_overflow), 32'(e.ovf));
            end
        end
    end

    task automatic cpu_write(input logic [AW-1:0] a, input logic [11:0] d);
        @(negedge clk);
        cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
        @(negedge clk);
        cpu_we = 1'b0;
    endtask

    task automatic cpu_read_chk(input string nm, input logic [AW-1:0] a, input logic [11:0] exp);
        @(negedge clk);
        cpu_addr = a; cpu_we = 1'b0;
        @(negedge clk);
        chk(nm, 32'(mem_rdata), 32'(exp));
    endtask

    task automatic push_exp(input int ch, input bit wr, input logic [11:0] rd, input bit ovf);
        exp_t e;
        e.ackv = '0;
        e.ackv[ch] = 1'b1;
        if (!wr) last_rdata = rd;
        e.data = last_rdata;
        e.ovf  = ovf;
        sb.push_back(e);
    endtask

    // One break on one channel; checks XA bus drive, ack cycle and hold length
    task automatic do_break(input string nm, input int ch, input bit wr, input bit three,
                            input logic [AW-1:0] addr, input logic [11:0] wd,
                            input logic [AW-1:0] xaddr, input logic [11:0] rd, input bit ovf);
        int k;
        int ack_k;
        int xa_k;
        xa_k = three ? 6 : 0;
        @(negedge clk);
        req = '0; req[ch] = 1'b1;
        to_mem[ch] = wr; three_cycle[ch] = three;
        ch_addr[ch*AW +: AW] = addr;
        ch_wdata[ch*12 +: 12] = wd;
        break_ok = 1'b1;
        push_exp(ch, wr, rd, ovf);
        @(negedge clk);
        // Scramble inputs after the grant: the latched values must be used
        req = '0; break_ok = 1'b0;
        ch_addr[ch*AW +: AW] = ~addr;
        ch_wdata[ch*12 +: 12] = ~wd;
        to_mem[ch] = ~wr;
        k = 0; ack_k = -1;
        while (cpu_hold && k < 20) begin
            if (k == xa_k) begin
                chk({nm, "_xa_addr"}, 32'(mem_addr), 32'(xaddr));
                chk({nm, "_xa_we"}, 32'(mem_we), 32'(wr));
                if (wr) chk({nm, "_xa_wdata"}, 32'(mem_wdata), 32'(wd));
            end
            if (ack != '0 && ack_k < 0) ack_k = k;
            @(negedge clk);
            k++;
        end
        chk({nm, "_hold_cycles"}, 32'(k), three ? 32'd9 : 32'd3);
        chk({nm, "_ack_cycle"}, 32'(ack_k), three ? 32'd8 : 32'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [CH-1:0] exp_rr [0:1];
        reset = 1'b1; break_ok = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
        req = '0; to_mem = '0; three_cycle = '0; ch_addr = '0; ch_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdata", 32'(ch_rdata), 32'd0);
        chk("rst_ovf", 32'(wc_overflow), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        reset = 1'b0;

        // Single-cycle write then CPU readback
        do_break("sc_wr", 0, 1'b1, 1'b0, 15'o10200, 12'o1234, 15'o10200, 12'o0, 1'b0);
        cpu_read_chk("sc_wr_mem", 15'o10200, 12'o1234);

        // Single-cycle read
        cpu_write(15'o00500, 12'o4321);
        do_break("sc_rd", 1, 1'b0, 1'b0, 15'o00500, 12'o0, 15'o00500, 12'o4321, 1'b0);

        // Arbitration: fixed keeps ch0, round robin alternates
        @(negedge clk);
        req = 2'b11; to_mem = 2'b00; three_cycle = 2'b00;
        ch_addr = {15'o10200, 15'o00500};
        break_ok = 1'b1;
        push_exp(0, 1'b0, 12'o4321, 1'b0);
        push_exp(0, 1'b0, 12'o4321, 1'b0);
        exp_rr[0] = 2'b01; exp_rr[1] = 2'b10;
        n = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                chk("rr_ack", 32'(ack_r), 32'(exp_rr[n]));
                n++;
                if (n == 2) begin
                    req = '0; break_ok = 1'b0;
                end
            end
        end
        chk("arb_ack_count", 32'(n), 32'd2);
        req = '0; break_ok = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Gating: request without break_ok never grants
        @(negedge clk);
        req = 2'b01; break_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("gate_hold", 32'(cpu_hold), 32'd0);
        end
        req = '0;

        // Three-cycle write, field 2
        cpu_write(15'o00030, 12'o7776);
        cpu_write(15'o00031, 12'o0177);
        do_break("tc1", 1, 1'b1, 1'b1, 15'o20030, 12'o0055, 15'o20200, 12'o0, 1'b0);
        cpu_read_chk("tc1_wc", 15'o00030, 12'o7777);
        cpu_read_chk("tc1_ca", 15'o00031, 12'o0200);
        cpu_read_chk("tc1_data", 15'o20200, 12'o0055);

        // Word count wraps to zero: overflow reported
        do_break("tc2", 1, 1'b1, 1'b1, 15'o20030, 12'o0066, 15'o20201, 12'o0, 1'b1);
        cpu_read_chk("tc2_wc", 15'o00030, 12'o0000);
        cpu_read_chk("tc2_ca", 15'o00031, 12'o0201);
        cpu_read_chk("tc2_data", 15'o20201, 12'o0066);

        // WC pointer 7777: CA lives at 0000; three-cycle read in field 1
        cpu_write(15'o07777, 12'o0005);
        cpu_write(15'o00000, 12'o0100);
        cpu_write(15'o10101, 12'o2222);
        do_break("wcp_wrap", 0, 1'b0, 1'b1, 15'o17777, 12'o0, 15'o10101, 12'o2222, 1'b0);
        cpu_read_chk("wcp_wrap_wc", 15'o07777, 12'o0006);
        cpu_read_chk("wcp_wrap_ca", 15'o00000, 12'o0101);

        // CA 7777 wraps within field 3
        cpu_write(15'o00040, 12'o1000);
        cpu_write(15'o00041, 12'o7777);
        do_break("ca_wrap", 0, 1'b1, 1'b1, 15'o30040, 12'o0777, 15'o30000, 12'o0, 1'b0);
        cpu_read_chk("ca_wrap_wc", 15'o00040, 12'o1001);
        cpu_read_chk("ca_wrap_ca", 15'o00041, 12'o0000);
        cpu_read_chk("ca_wrap_data", 15'o30000, 12'o0777);

        // Reset during CD abandons the break
        cpu_write(15'o00060, 12'o0010);
        cpu_write(15'o00061, 12'o0300);
        cpu_write(15'o40301, 12'o1111);
        @(negedge clk);
        req = 2'b01; to_mem = 2'b01; three_cycle = 2'b01;
        ch_addr[0 +: AW] = 15'o40060; ch_wdata[0 +: 12] = 12'o5555;
        break_ok = 1'b1;
        @(negedge clk);
        req = '0; break_ok = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid_hold_before", 32'(cpu_hold), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_hold", 32'(cpu_hold), 32'd0);
        chk("rst_mid_we", 32'(mem_we), 32'd0);
        chk("rst_mid_ack", 32'(ack), 32'd0);
        chk("rst_mid_rdata", 32'(ch_rdata), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cpu_read_chk("rst_mid_xfer", 15'o40301, 12'o1111);
        cpu_read_chk("rst_mid_ca", 15'o00061, 12'o0300);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
